// File: rtl/seq_detect_mealy_pkg.sv
// Shared helpers for seq_detect_mealy: ceil-log2, fill-counter width and parameter legality.
// Optional feature macro used by the block: MATCH_COUNT_EN.
package seq_detect_mealy_pkg;

    localparam int DEF_PAT_W = 4;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // fill counts 0..PAT_W-1, so ceil(log2(PAT_W)) bits always suffice
    function automatic int fill_width(input int pat_w);
        return (clog2(pat_w) < 1) ? 1 : clog2(pat_w);
    endfunction

    localparam int DEF_FILL_W = fill_width(DEF_PAT_W);

    function automatic bit params_legal(input int pat_w, input int pat_bits, input int cnt_w);
        return (pat_w >= 2) && (pat_w <= 16) && (pat_bits == pat_w) && (cnt_w >= 1);
    endfunction

endpackage

// File: rtl/seq_detect_mealy_sat_counter.sv
// Saturating up-counter with enable and asynchronous active-low clear.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic         en,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_MAX = '1;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn)
            cnt <= '0;
        else if (en && (cnt != CNT_MAX))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/seq_detect_mealy.sv
// Parametrised Mealy serial-pattern detector; z flags the cycle the last pattern bit arrives.
// Define MATCH_COUNT_EN to add the saturating match_cnt output.
module seq_detect_mealy
    import seq_detect_mealy_pkg::*;
#(
    parameter int PAT_W   = 4,
    parameter     PATTERN = 4'b1011,
    parameter bit OVERLAP = 1'b1,
    parameter int CNT_W   = 8
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             en,
    input  logic             w,
`ifdef MATCH_COUNT_EN
    output logic [CNT_W-1:0] match_cnt,
`endif
    output logic             z
);

    localparam int                FILL_W   = fill_width(PAT_W);
    localparam logic [PAT_W-1:0]  PAT      = PATTERN;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    if (!params_legal(PAT_W, $bits(PATTERN), CNT_W)) begin : g_bad_params
        $error("seq_detect_mealy: PAT_W must be 2..16 and match the PATTERN width");
    end

    logic [PAT_W-2:0]  hist, hist_nxt;
    logic [FILL_W-1:0] fill, fill_nxt;
    logic [PAT_W-1:0]  window;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            hist <= '0;
            fill <= '0;
        end else begin
            hist <= hist_nxt;
            fill <= fill_nxt;
        end
    end

    // en gates z first so an undriven w while idle cannot reach the output
    always_comb begin
        window   = {hist, w};
        z        = en && (fill == FILL_MAX) && (window == PAT);
        hist_nxt = hist;
        fill_nxt = fill;
        if (en) begin
            hist_nxt = window[PAT_W-2:0];
            if (z && !OVERLAP)
                fill_nxt = '0;
            else if (fill != FILL_MAX)
                fill_nxt = fill + 1'b1;
        end
    end

`ifdef MATCH_COUNT_EN
    sat_counter #(
        .W      (CNT_W)
    ) u_match_cnt (
        .Clock  (Clock),
        .Resetn (Resetn),
        .en     (z),
        .cnt    (match_cnt)
    );
`endif

endmodule
